// File: rtl/riscv_hazard_unit.sv
// RAW hazard detection, long-op scoreboard, E-stage forwarding selects and stall counter for F/D/E/M/B.
// Hold/flush are combinational in the cycle. Forward selects, scoreboard and counter update on clk.
module riscv_hazard_unit #(
    parameter int NSRC   = 2,
    parameter int REG_AW = 5,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NSRC-1:0]          i_src_en,
    input  logic [NSRC*REG_AW-1:0]   i_src_addr,
    input  logic [REG_AW-1:0]        i_dst_addrD,
    input  logic                     i_long_issue,
    input  logic                     i_dst_enE,
    input  logic                     i_dst_enM,
    input  logic                     i_dst_enB,
    input  logic [REG_AW-1:0]        i_dst_addrE,
    input  logic [REG_AW-1:0]        i_dst_addrM,
    input  logic [REG_AW-1:0]        i_dst_addrB,
    input  logic                     i_loadE,
    input  logic                     i_long_done,
    input  logic [REG_AW-1:0]        i_long_done_addr,
    input  logic                     i_ex_branchM,
    input  logic                     i_jalD,
    input  logic                     i_bus_stallM,
    input  logic                     i_cnt_clr,
    output logic                     o_holdF,
    output logic [3:0]               o_hold,
    output logic [3:0]               o_flush,
    output logic [2*NSRC-1:0]        o_fwd_selE,
    output logic [CNT_W-1:0]         o_stall_cnt
);
    localparam int NREG = 1 << REG_AW;

    logic [NREG-1:0]   r_sb;
    logic [2*NSRC-1:0] r_fwd_sel;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic [NSRC-1:0]   w_matchE;
    logic [NSRC-1:0]   w_matchM;
    logic [NSRC-1:0]   w_sb_any;
    logic [NSRC-1:0]   w_sb_wait;
    logic [NSRC-1:0]   w_done_hit;
    logic [2*NSRC-1:0] w_fwd_nxt;
    logic              w_data_stall;
    logic              w_issue;
    logic              w_holdF;
    logic [3:0]        w_hold;
    logic [3:0]        w_flush;
    logic [NREG-1:0]   w_sb_set;
    logic [NREG-1:0]   w_sb_clr;
    logic              w_unused_b;

    // The regfile is write-first, so a B-stage producer is already visible to D.
    assign w_unused_b = ^{i_dst_enB, i_dst_addrB};

    for (genvar k = 0; k < NSRC; k++) begin : g_src
        logic [REG_AW-1:0] w_a;
        logic              w_live;

        assign w_a           = i_src_addr[k*REG_AW +: REG_AW];
        assign w_live        = i_src_en[k] && (w_a != '0);
        assign w_matchE[k]   = w_live && i_dst_enE && (w_a == i_dst_addrE);
        assign w_matchM[k]   = w_live && i_dst_enM && (w_a == i_dst_addrM);
        assign w_done_hit[k] = w_live && i_long_done && (w_a == i_long_done_addr);
        assign w_sb_any[k]   = w_live && r_sb[w_a];
        assign w_sb_wait[k]  = w_sb_any[k] && !w_done_hit[k];
        assign w_fwd_nxt[2*k +: 2] = w_matchE[k]   ? 2'd1 :
                                     w_matchM[k]   ? 2'd2 :
                                     w_done_hit[k] ? 2'd3 : 2'd0;
    end

    assign w_data_stall = (FWD_EN != 0) ? (((|w_matchE) && i_loadE) || (|w_sb_wait))
                                        : ((|w_matchE) || (|w_matchM) || (|w_sb_any));

    assign w_issue = !i_bus_stallM && !i_ex_branchM && !w_data_stall;

    // Gating by rst_n makes an asserted reset release every hold immediately.
    always_comb begin
        w_holdF = 1'b0;
        w_hold  = 4'b0000;
        w_flush = 4'b0000;
        if (!rst_n) begin
            w_holdF = 1'b0;
        end else if (i_bus_stallM) begin
            w_holdF = 1'b1;
            w_hold  = 4'b1111;
        end else if (i_ex_branchM) begin
            w_flush = 4'b1110;
        end else if (w_data_stall) begin
            w_holdF = 1'b1;
            w_hold  = 4'b1000;
            w_flush = 4'b0100;
        end else if (i_jalD) begin
            w_flush = 4'b1000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fwd_sel <= '0;
        end else if (FWD_EN == 0) begin
            r_fwd_sel <= '0;
        end else if (!w_hold[2]) begin
            if (w_flush[2]) begin
                r_fwd_sel <= '0;
            end else if (w_issue) begin
                r_fwd_sel <= w_fwd_nxt;
            end
        end
    end

    // Set is OR-ed in after the clear so a same-address set/clear leaves the bit set.
    assign w_sb_set = (w_issue && i_long_issue && (i_dst_addrD != '0)) ?
                      (NREG'(1) << i_dst_addrD) : '0;
    assign w_sb_clr = i_long_done ? (NREG'(1) << i_long_done_addr) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sb <= '0;
        end else begin
            r_sb <= (r_sb & ~w_sb_clr) | w_sb_set;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (i_cnt_clr) begin
            r_stall_cnt <= '0;
        end else if (w_holdF && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign o_holdF     = w_holdF;
    assign o_hold      = w_hold;
    assign o_flush     = w_flush;
    assign o_fwd_selE  = r_fwd_sel;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_riscv_hazard_unit.sv
// Two units share stimulus: u_fwd (forwarding, NSRC=2, CNT_W=4) and u_nofwd (stall-only, NSRC=3).
// Each cycle both are compared against a source-level reference model of the pipeline rules.
module tb_riscv_hazard_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  src_en;
    logic [14:0] src_addr;
    logic [4:0]  dst_addrD, dst_addrE, dst_addrM, dst_addrB, long_done_addr;
    logic        long_issue, dst_enE, dst_enM, dst_enB, loadE, long_done;
    logic        branchM, jalD, bus_stallM, cnt_clr;

    logic        holdF0, holdF1;
    logic [3:0]  hold0, hold1, flush0, flush1;
    logic [3:0]  fwd0;
    logic [5:0]  fwd1;
    logic [3:0]  cnt0;
    logic [15:0] cnt1;

    int total = 0;
    int bad   = 0;

    bit         sb [2][32];
    logic [5:0] m_sel [2];
    int         m_cnt [2];
    logic       obs_holdF [2];
    logic [3:0] obs_hold [2];
    logic [3:0] obs_flush [2];

    always #5 clk = ~clk;

    riscv_hazard_unit #(.NSRC(2), .REG_AW(5), .FWD_EN(1), .CNT_W(4)) u_fwd (
        .clk(clk), .rst_n(rst_n), .i_src_en(src_en[1:0]), .i_src_addr(src_addr[9:0]),
        .i_dst_addrD(dst_addrD), .i_long_issue(long_issue),
        .i_dst_enE(dst_enE), .i_dst_enM(dst_enM), .i_dst_enB(dst_enB),
        .i_dst_addrE(dst_addrE), .i_dst_addrM(dst_addrM), .i_dst_addrB(dst_addrB),
        .i_loadE(loadE), .i_long_done(long_done), .i_long_done_addr(long_done_addr),
        .i_ex_branchM(branchM), .i_jalD(jalD), .i_bus_stallM(bus_stallM), .i_cnt_clr(cnt_clr),
        .o_holdF(holdF0), .o_hold(hold0), .o_flush(flush0), .o_fwd_selE(fwd0), .o_stall_cnt(cnt0)
    );

    riscv_hazard_unit #(.NSRC(3), .REG_AW(5), .FWD_EN(0), .CNT_W(16)) u_nofwd (
        .clk(clk), .rst_n(rst_n), .i_src_en(src_en), .i_src_addr(src_addr),
        .i_dst_addrD(dst_addrD), .i_long_issue(long_issue),
        .i_dst_enE(dst_enE), .i_dst_enM(dst_enM), .i_dst_enB(dst_enB),
        .i_dst_addrE(dst_addrE), .i_dst_addrM(dst_addrM), .i_dst_addrB(dst_addrB),
        .i_loadE(loadE), .i_long_done(long_done), .i_long_done_addr(long_done_addr),
        .i_ex_branchM(branchM), .i_jalD(jalD), .i_bus_stallM(bus_stallM), .i_cnt_clr(cnt_clr),
        .o_holdF(holdF1), .o_hold(hold1), .o_flush(flush1), .o_fwd_selE(fwd1), .o_stall_cnt(cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        src_en = '0; src_addr = '0; dst_addrD = '0; long_issue = 1'b0;
        dst_enE = 1'b0; dst_enM = 1'b0; dst_enB = 1'b0;
        dst_addrE = '0; dst_addrM = '0; dst_addrB = '0; loadE = 1'b0;
        long_done = 1'b0; long_done_addr = '0;
        branchM = 1'b0; jalD = 1'b0; bus_stallM = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            for (int r = 0; r < 32; r++) sb[u][r] = 1'b0;
            m_sel[u] = '0;
            m_cnt[u] = 0;
        end
    endtask

    // Evaluate one unit's rules for the current inputs, compare, then advance its state.
    task automatic model_unit(input int u);
        int         ns   = (u == 0) ? 2 : 3;
        bit         fwd  = (u == 0);
        int         cmax = (u == 0) ? 15 : 65535;
        bit         hazE = 0, hazM = 0, hazSB = 0, sbwait = 0, stall, issue;
        bit         e_holdF = 0;
        logic [3:0] e_hold = 4'b0000, e_flush = 4'b0000;
        logic [5:0] fsel = '0;
        logic [4:0] a;
        bit         mE, mM, dh;
        logic       oh;
        logic [3:0] ohd, ofl;
        logic [5:0] osel;
        int         ocnt;

        for (int k = 0; k < ns; k++) begin
            a = src_addr[k*5 +: 5];
            if (src_en[k] && a != 0) begin
                mE = dst_enE && (a == dst_addrE);
                mM = dst_enM && (a == dst_addrM);
                dh = long_done && (a == long_done_addr);
                if (mE) hazE = 1;
                if (mM) hazM = 1;
                if (sb[u][a]) begin
                    hazSB = 1;
                    if (!dh) sbwait = 1;
                end
                fsel[2*k +: 2] = mE ? 2'd1 : mM ? 2'd2 : dh ? 2'd3 : 2'd0;
            end
        end
        stall = fwd ? ((hazE && loadE) || sbwait) : (hazE || hazM || hazSB);
        if (bus_stallM) begin
            e_holdF = 1; e_hold = 4'b1111;
        end else if (branchM) begin
            e_flush = 4'b1110;
        end else if (stall) begin
            e_holdF = 1; e_hold = 4'b1000; e_flush = 4'b0100;
        end else if (jalD) begin
            e_flush = 4'b1000;
        end
        issue = !bus_stallM && !branchM && !stall;

        if (u == 0) begin
            oh = holdF0; ohd = hold0; ofl = flush0; osel = {2'b00, fwd0}; ocnt = int'(cnt0);
        end else begin
            oh = holdF1; ohd = hold1; ofl = flush1; osel = fwd1; ocnt = int'(cnt1);
        end
        obs_holdF[u] = oh; obs_hold[u] = ohd; obs_flush[u] = ofl;
        chk($sformatf("u%0d_holdF", u), 32'(oh), 32'(e_holdF));
        chk($sformatf("u%0d_hold", u), 32'(ohd), 32'(e_hold));
        chk($sformatf("u%0d_flush", u), 32'(ofl), 32'(e_flush));
        chk($sformatf("u%0d_fwdsel", u), 32'(osel), 32'(m_sel[u]));
        chk($sformatf("u%0d_cnt", u), 32'(ocnt), 32'(m_cnt[u]));

        if (fwd && !bus_stallM) m_sel[u] = (branchM || stall) ? 6'd0 : fsel;
        if (long_done) sb[u][long_done_addr] = 1'b0;
        if (issue && long_issue && dst_addrD != 0) sb[u][dst_addrD] = 1'b1;
        if (cnt_clr) m_cnt[u] = 0;
        else if (e_holdF && m_cnt[u] < cmax) m_cnt[u]++;
    endtask

    task automatic step();
        @(negedge clk);
        model_unit(0);
        model_unit(1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        logic [3:0] saved;
        idle();
        model_reset();
        rst_n = 1'b0;
        bus_stallM = 1'b1;
        #3;
        chk("rst_holdF0", 32'(holdF0), 0);
        chk("rst_hold0", 32'(hold0), 0);
        chk("rst_hold1", 32'(hold1), 0);
        chk("rst_fwd0", 32'(fwd0), 0);
        chk("rst_cnt0", 32'(cnt0), 0);
        #9;
        rst_n = 1'b1;
        idle();
        @(posedge clk);
        #1;

        // add x5 in E, D reads x5
        dst_enE = 1; dst_addrE = 5; src_en = 3'b001; src_addr[4:0] = 5;
        step();
        chk("alu_nostall", 32'(obs_holdF[0]), 0);
        chk("alu_sel1", 32'(fwd0[1:0]), 1);

        // lw x5 in E, D reads x5, then producer moves to M
        loadE = 1;
        step();
        chk("lu_holdF", 32'(obs_holdF[0]), 1);
        chk("lu_hold", 32'(obs_hold[0]), 32'h8);
        chk("lu_flush", 32'(obs_flush[0]), 32'h4);
        loadE = 0; dst_enE = 0; dst_enM = 1; dst_addrM = 5;
        step();
        chk("lu_issue", 32'(obs_holdF[0]), 0);
        chk("lu_sel2", 32'(fwd0[1:0]), 2);
        chk("lu_cnt", 32'(cnt0), 1);

        // bus stall dominates branch and load-use
        saved = fwd0;
        idle();
        bus_stallM = 1; branchM = 1; dst_enE = 1; dst_addrE = 6; loadE = 1;
        src_en = 3'b010; src_addr[9:5] = 6;
        step();
        chk("bus_hold", 32'(obs_hold[0]), 32'hF);
        chk("bus_flush", 32'(obs_flush[0]), 0);
        chk("bus_selkeep", 32'(fwd0), 32'(saved));

        // div to x7, consumer waits 10 cycles, issues on the done cycle
        idle();
        long_issue = 1; dst_addrD = 7;
        step();
        idle();
        src_en = 3'b001; src_addr[4:0] = 7;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            n += int'(obs_holdF[0]);
        end
        chk("div_stalls", 32'(n), 10);
        long_done = 1; long_done_addr = 7;
        step();
        chk("div_done_issue", 32'(obs_holdF[0]), 0);
        chk("div_sel3", 32'(fwd0[1:0]), 3);
        long_done = 0;
        step();
        chk("div_sb_clear", 32'(obs_holdF[0]), 0);

        // stall-only: producer x3 in M, then in B; x0 never stalls
        idle();
        dst_enM = 1; dst_addrM = 3; src_en = 3'b001; src_addr[4:0] = 3;
        step();
        chk("nofwd_m_stall", 32'(obs_holdF[1]), 1);
        dst_enM = 0; dst_enB = 1; dst_addrB = 3;
        step();
        chk("nofwd_b_go", 32'(obs_holdF[1]), 0);
        idle();
        dst_enE = 1; loadE = 1; dst_enM = 1; src_en = 3'b111;
        step();
        chk("x0_fwd", 32'(obs_holdF[0]), 0);
        chk("x0_nofwd", 32'(obs_holdF[1]), 0);

        // counter saturation and clear
        idle();
        cnt_clr = 1;
        step();
        cnt_clr = 0; bus_stallM = 1;
        for (int i = 0; i < 20; i++) step();
        chk("cnt_sat", 32'(cnt0), 15);
        cnt_clr = 1;
        step();
        chk("cnt_clr", 32'(cnt0), 0);

        // reset asserted in the middle of a load-use stall
        idle();
        dst_enE = 1; dst_addrE = 9; loadE = 1; src_en = 3'b001; src_addr[4:0] = 9;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mrst_holdF0", 32'(holdF0), 0);
        chk("mrst_holdF1", 32'(holdF1), 0);
        chk("mrst_hold0", 32'(hold0), 0);
        chk("mrst_flush0", 32'(flush0), 0);
        chk("mrst_cnt1", 32'(cnt1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        @(posedge clk);
        #1;

        // randomized traffic over a small register window
        for (int i = 0; i < 800; i++) begin
            src_en = 3'($urandom);
            for (int k = 0; k < 3; k++) src_addr[k*5 +: 5] = 5'($urandom_range(0, 3));
            dst_addrD      = 5'($urandom_range(0, 3));
            long_issue     = ($urandom_range(0, 3) == 0);
            dst_enE        = $urandom_range(0, 1) == 1;
            dst_enM        = $urandom_range(0, 1) == 1;
            dst_enB        = $urandom_range(0, 1) == 1;
            dst_addrE      = 5'($urandom_range(0, 3));
            dst_addrM      = 5'($urandom_range(0, 3));
            dst_addrB      = 5'($urandom_range(0, 3));
            loadE          = $urandom_range(0, 1) == 1;
            long_done      = ($urandom_range(0, 3) == 0);
            long_done_addr = 5'($urandom_range(0, 3));
            branchM        = ($urandom_range(0, 7) == 0);
            jalD           = ($urandom_range(0, 3) == 0);
            bus_stallM     = ($urandom_range(0, 7) == 0);
            cnt_clr        = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/riscv_hazard_unit.md
# riscv_hazard_unit

Parametrised hazard, forwarding and scoreboard controller for the five-stage F/D/E/M/B RISC-V pipeline. Detects RAW hazards at the D stage against in-flight E/M/B destinations and outstanding long-latency writes such as mul/div or uncached loads. Generates per-stage hold/flush controls, registered forwarding selects for the E stage, and a saturating stall-cycle counter. Supports forwarding-on and stall-only modes.

## Interface
- NSRC, 2: number of source operands checked per instruction (2 or 3).
- REG_AW, 5: register address width; the scoreboard has 2**REG_AW entries.
- FWD_EN, 1: 1 = forwarding mode; 0 = stall-only mode.
- CNT_W, 16: stall counter width.
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- i_src_en  in  NSRC  per-source read enable (D stage)
- i_src_addr  in  NSRC*REG_AW  source addresses, source k at bits [k*REG_AW +: REG_AW]
- i_dst_addrD  in  REG_AW  destination of the D-stage instruction
- i_long_issue  in  1  D-stage instruction is a long-latency writer of i_dst_addrD
- i_dst_enE / i_dst_enM / i_dst_enB  in  1 each  stage writes a register
- i_dst_addrE / i_dst_addrM / i_dst_addrB  in  REG_AW each  stage destination
- i_loadE  in  1  E-stage instruction is a load
- i_long_done  in  1  long-latency result valid this cycle
- i_long_done_addr  in  REG_AW  its destination
- i_ex_branchM  in  1  taken branch or redirect resolved in M
- i_jalD  in  1  jal decoded in D
- i_bus_stallM  in  1  M-stage bus not ready
- i_cnt_clr  in  1  synchronous clear of the stall counter
- o_holdF  out  1  hold PC
- o_hold  out  4  hold {FD,DE,EM,MB} registers, 1 = keep
- o_flush  out  4  flush {FD,DE,EM,MB} registers, 1 = insert bubble
- o_fwd_selE  out  2*NSRC  per-source E-stage operand select: 0 = RF, 1 = M result, 2 = B result, 3 = long-done bus
- o_stall_cnt  out  CNT_W  saturating count of cycles with o_holdF = 1

## Operation
- A source k "matches" stage X when i_src_en[k] = 1, the source address is nonzero, i_dst_enX = 1 and the addresses are equal. Register 0 never matches.
- Regfile is write-first, so a B-stage match needs no action.
- hazE: any source matches E. hazM: any source matches M. hazSB: any enabled, nonzero source has its scoreboard bit set.
- FWD_EN = 1: data stall = (hazE and i_loadE) or (hazSB and not (i_long_done and i_long_done_addr equals that source)).
- FWD_EN = 0: data stall = hazE or hazM or hazSB.
- Control priority, highest first:
  1. bus: i_bus_stallM gives o_holdF = 1, o_hold = 1111, o_flush = 0000.
  2. branch: i_ex_branchM gives o_flush = 1110, no hold.
  3. data stall gives o_holdF = 1, o_hold = 1000, o_flush = 0100.
  4. jal: i_jalD gives o_flush = 1000.
  5. otherwise all 0.
- D advances ("issue") when no bus stall, no branch and no data stall.
- Forward select per source, computed in D: E match gives 1 (nearest wins), else M match gives 2, else a same-cycle long_done hit gives 3, else 0.
- o_fwd_selE register:
  - Loaded on issue.
  - Cleared to 0 when DE is flushed.
  - Held when DE is held.
  - Forced to 0 when FWD_EN = 0.
- Scoreboard:
  - Set on issue with i_long_issue and i_dst_addrD nonzero.
  - Cleared on i_long_done at i_long_done_addr.
  - Set and clear of the same address in one cycle: set wins.
  - The scoreboard is not cleared by branch flush, because the long op is already committed in the unit.
- Stall counter: increments when o_holdF = 1, saturates at 2**CNT_W-1. i_cnt_clr has priority over increment.

## Timing
- Hold/flush outputs are combinational from inputs and registered state, valid in the same cycle.
- o_fwd_selE, the scoreboard and o_stall_cnt update on the rising clk edge.
- While rst_n = 0: o_hold = 0, o_flush = 0, o_holdF = 0, o_fwd_selE = 0, scoreboard all 0, o_stall_cnt = 0. Reset asserted mid-stall drops all holds immediately.
- A load-use hazard costs exactly 1 cycle; the following cycle the producer is in M, giving fwd select 2.
- A long-op dependency stalls until the i_long_done cycle; with FWD_EN = 1 the consumer issues in that same cycle with select 3.

## Test plan
- FWD_EN = 1, add x5 in E, D reads x5 -> no stall; after the clock, o_fwd_selE source 0 = 1.
- lw x5 in E (i_loadE = 1), D reads x5 -> o_holdF = 1, o_hold = 1000, o_flush = 0100 for 1 cycle; the next issue has select 2; o_stall_cnt = 1.
- div issued to x7, done after 10 cycles, D reads x7 -> 10 stall cycles, issue on the done cycle with select 3; scoreboard bit 7 clear afterwards.
- i_bus_stallM = 1 together with i_ex_branchM = 1 and a load-use hazard -> o_hold = 1111, o_flush = 0000, o_fwd_selE unchanged.
- FWD_EN = 0, producer x3 in M, D reads x3 -> stall until the producer reaches B; reads of x0 never stall.
- o_stall_cnt with CNT_W = 4 under 20 stall cycles -> saturates at 15; i_cnt_clr -> 0; rst_n low mid-stall -> all outputs 0 asynchronously.
